// File: rtl/gbe_tx_frame_arbiter.sv
// gbe_tx_frame_arbiter: round-robin, frame-granular arbiter onto the 10GbE TX port.
// Ports: req_* frame sources in, tx_* to the core, grant/busy/trunc/ovf status out.
module gbe_tx_frame_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(MAX_WORDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [64*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]    req_eof,
  input  logic [32*N_REQ-1:0] req_dest_ip,
  input  logic [16*N_REQ-1:0] req_dest_port,
  output logic                tx_valid,
  output logic [63:0]         tx_data,
  output logic                tx_end_of_frame,
  output logic [31:0]         tx_dest_ip,
  output logic [15:0]         tx_dest_port,
  input  logic                tx_afull,
  input  logic                tx_overflow,
  output logic [IW-1:0]       grant_id,
  output logic                busy,
  output logic                trunc_pulse,
  output logic [CNT_W-1:0]    trunc_cnt,
  output logic [CNT_W-1:0]    ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DROP
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic [CW-1:0] cnt;
  logic [31:0]   ip_q;
  logic [15:0]   port_q;
  logic          g_valid;
  logic          g_eof;
  logic [63:0]   g_data;
  logic          last_word;
  logic          start;
  logic          acc;
  logic          dacc;

  assign g_valid   = req_valid[grant_id];
  assign g_eof     = req_eof[grant_id];
  assign g_data    = req_data[64*grant_id +: 64];
  assign last_word = (cnt == CW'(MAX_WORDS - 1));
  assign start     = (state == IDLE) && en && (|req_valid);

  // Scan from farthest to nearest so the first valid after rr_ptr wins.
  always_comb begin
    pick = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % N_REQ])
        pick = IW'((int'(rr_ptr) + k) % N_REQ);
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    acc       = 1'b0;
    dacc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = SEND;
      end
      SEND: begin
        acc = g_valid & ~tx_afull;
        req_ready[grant_id] = acc;
        if (acc && g_eof)
          state_nxt = IDLE;
        else if (acc && last_word)
          state_nxt = DROP;
      end
      DROP: begin
        dacc = g_valid;
        req_ready[grant_id] = dacc;
        if (dacc && g_eof)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr          <= IW'(N_REQ - 1);
      grant_id        <= '0;
      cnt             <= '0;
      ip_q            <= '0;
      port_q          <= '0;
      busy            <= 1'b0;
      tx_valid        <= 1'b0;
      tx_data         <= '0;
      tx_end_of_frame <= 1'b0;
      tx_dest_ip      <= '0;
      tx_dest_port    <= '0;
      trunc_pulse     <= 1'b0;
      trunc_cnt       <= '0;
      ovf_cnt         <= '0;
    end else begin
      busy            <= (state_nxt != IDLE);
      tx_valid        <= acc;
      tx_end_of_frame <= acc & (g_eof | last_word);
      trunc_pulse     <= acc & ~g_eof & last_word;
      if (start) begin
        grant_id <= pick;
        ip_q     <= req_dest_ip[32*pick +: 32];
        port_q   <= req_dest_port[16*pick +: 16];
        cnt      <= '0;
      end
      if (acc) begin
        tx_data      <= g_data;
        tx_dest_ip   <= ip_q;
        tx_dest_port <= port_q;
        cnt          <= g_eof ? '0 : cnt + 1'b1;
      end
      if ((acc || dacc) && g_eof)
        rr_ptr <= grant_id;
      if (acc && !g_eof && last_word && trunc_cnt != '1)
        trunc_cnt <= trunc_cnt + 1'b1;
      if (tx_overflow && ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gbe_tx_frame_arbiter.sv
// tb_gbe_tx_frame_arbiter: directed + randomized frames vs a frame-level model.
// Requester queues feed the DUT; expected TX words come from round-robin over frames.
module tb_gbe_tx_frame_arbiter;

  localparam int N    = 4;
  localparam int MAXW = 8;
  localparam int CW   = 2;
  localparam int IW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [64*N-1:0] req_data;
  logic [N-1:0]    req_eof;
  logic [32*N-1:0] req_dest_ip;
  logic [16*N-1:0] req_dest_port;
  logic            tx_valid;
  logic [63:0]     tx_data;
  logic            tx_end_of_frame;
  logic [31:0]     tx_dest_ip;
  logic [15:0]     tx_dest_port;
  logic            tx_afull;
  logic            tx_overflow;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            trunc_pulse;
  logic [CW-1:0]   trunc_cnt;
  logic [CW-1:0]   ovf_cnt;

  always #5 clk = ~clk;

  gbe_tx_frame_arbiter #(
    .N_REQ(N),
    .MAX_WORDS(MAXW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .req_eof(req_eof),
    .req_dest_ip(req_dest_ip),
    .req_dest_port(req_dest_port),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_end_of_frame(tx_end_of_frame),
    .tx_dest_ip(tx_dest_ip),
    .tx_dest_port(tx_dest_port),
    .tx_afull(tx_afull),
    .tx_overflow(tx_overflow),
    .grant_id(grant_id),
    .busy(busy),
    .trunc_pulse(trunc_pulse),
    .trunc_cnt(trunc_cnt),
    .ovf_cnt(ovf_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
    bit          first;
  } word_t;

  typedef struct {
    logic [63:0] data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
    logic        trunc;
  } exp_t;

  word_t rq [N][$];
  exp_t  expq[$];

  int nvec = 0;
  int nerr = 0;
  int m_rr;
  int exp_trunc;
  int exp_ovf;
  int fid = 0;
  int cyc = 0;
  int last_valid_cyc;
  int last_eof_cyc;
  bit in_frame;
  bit strict;
  bit bub_en;
  bit rand_afull;
  int ovf_pct;
  bit prev_afull;
  logic [N-1:0] bubble;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]              = !bubble[i];
        req_data[64*i +: 64]      = rq[i][0].data;
        req_eof[i]                = rq[i][0].eof;
        req_dest_ip[32*i +: 32]   = rq[i][0].ip;
        req_dest_port[16*i +: 16] = rq[i][0].port;
      end else begin
        req_valid[i]              = 1'b0;
        req_data[64*i +: 64]      = '0;
        req_eof[i]                = 1'b0;
        req_dest_ip[32*i +: 32]   = '0;
        req_dest_port[16*i +: 16] = '0;
      end
    end
  endtask

  task automatic add_frame(input int r, input int len);
    word_t w;
    logic [31:0] ip;
    logic [15:0] port;
    ip   = $urandom;
    port = 16'($urandom);
    for (int j = 0; j < len; j++) begin
      w.data  = {8'(r), 8'(fid), 16'(j), 32'($urandom)};
      w.eof   = (j == len - 1);
      w.ip    = ip;
      w.port  = port;
      w.first = (j == 0);
      rq[r].push_back(w);
    end
    fid++;
    drive();
  endtask

  // Frame-level round robin over everything queued, truncating at MAXW words.
  task automatic plan();
    word_t snap [N][$];
    word_t w;
    exp_t  e;
    int p;
    int n;
    for (int i = 0; i < N; i++) snap[i] = rq[i];
    forever begin
      p = -1;
      for (int k = 1; k <= N; k++) begin
        if (p < 0 && snap[(m_rr + k) % N].size() > 0) p = (m_rr + k) % N;
      end
      if (p < 0) break;
      e.ip   = snap[p][0].ip;
      e.port = snap[p][0].port;
      n = 0;
      do begin
        w = snap[p].pop_front();
        n++;
        if (n <= MAXW) begin
          e.data  = w.data;
          e.eof   = w.eof || (n == MAXW);
          e.trunc = (n == MAXW) && !w.eof;
          if (e.trunc && exp_trunc < (1 << CW) - 1) exp_trunc++;
          expq.push_back(e);
        end
      end while (!w.eof);
      m_rr = p;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] rdy;
    exp_t e;
    @(negedge clk);
    cyc++;
    rdy = req_ready;
    chk("ready_onehot", {127'b0, ($onehot0(req_ready) &&
        ((req_ready & ~req_valid) == '0))}, 128'd1);
    if (prev_afull) chk("afull_stall", tx_valid, 0);
    if (tx_valid) begin
      if (expq.size() == 0) begin
        chk("extra_word", expq.size(), 1);
      end else begin
        e = expq.pop_front();
        chk("tx_word",
            {tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port, trunc_pulse},
            {e.data, e.eof, e.ip, e.port, e.trunc});
        if (strict) begin
          if (in_frame) chk("burst", cyc - last_valid_cyc, 1);
          else if (last_eof_cyc > 0) chk("frame_gap", cyc - last_eof_cyc, 2);
        end
        last_valid_cyc = cyc;
        in_frame = !e.eof;
        if (e.eof) last_eof_cyc = cyc;
      end
    end else begin
      chk("idle_trunc", trunc_pulse, 0);
    end
    prev_afull = tx_afull;
    if (tx_overflow && exp_ovf < (1 << CW) - 1) exp_ovf++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    tx_overflow = (ovf_pct > 0) && ($urandom_range(0, 99) < ovf_pct);
    if (rand_afull) tx_afull = ($urandom_range(0, 99) < 25);
    for (int i = 0; i < N; i++)
      bubble[i] = bub_en && rq[i].size() > 0 && !rq[i][0].first &&
                  ($urandom_range(0, 99) < 25);
    drive();
  endtask

  task automatic run(input int budget);
    int n = 0;
    last_eof_cyc = 0;
    in_frame = 0;
    while ((expq.size() > 0 || pending() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("phase_done", expq.size() + pending(), 0);
    repeat (3) cycle();
    chk("trunc_cnt", trunc_cnt, exp_trunc);
    chk("ovf_cnt", ovf_cnt, exp_ovf);
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("reset_out",
        {tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
         grant_id, busy, trunc_pulse, req_ready},
        0);
    chk("reset_cnt", {trunc_cnt, ovf_cnt}, 0);
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b1;
    tx_afull = 1'b0;
    tx_overflow = 1'b0;
    bubble = '0;
    strict = 0;
    bub_en = 0;
    rand_afull = 0;
    ovf_pct = 0;
    prev_afull = 0;
    m_rr = N - 1;
    exp_trunc = 0;
    exp_ovf = 0;
    drive();
    repeat (3) cycle();
    chk_reset_outputs();
    rst = 1'b1;

    // 3-word frame from req0, back to back
    strict = 1;
    add_frame(0, 3);
    plan();
    run(100);
    chk("grant_req0", grant_id, 0);

    // all four requesters, 2-word frames, req0 twice
    for (int i = 0; i < N; i++) add_frame(i, 2);
    add_frame(0, 2);
    plan();
    run(200);
    strict = 0;

    // tx_afull held for 5 cycles mid-frame
    add_frame(1, 10);
    plan();
    repeat (4) cycle();
    tx_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_ready", req_ready, 0);
    end
    tx_afull = 1'b0;
    run(200);

    // oversize frame truncated, next frame follows
    add_frame(2, 12);
    add_frame(3, 2);
    plan();
    run(200);

    // overflow pulses, saturating at 3
    for (int i = 0; i < 3; i++) begin
      tx_overflow = 1'b1;
      cycle();
    end
    cycle();
    chk("ovf_3", ovf_cnt, 3);
    for (int i = 0; i < 2; i++) begin
      tx_overflow = 1'b1;
      cycle();
    end
    cycle();
    chk("ovf_sat", ovf_cnt, exp_ovf);

    // en low holds off new grants
    en = 1'b0;
    add_frame(1, 2);
    repeat (5) cycle();
    chk("en_low_busy", busy, 0);
    en = 1'b1;
    plan();
    run(100);

    // randomized frames with bubbles, afull and overflow
    bub_en = 1;
    rand_afull = 1;
    ovf_pct = 5;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        for (int f = 0; f < int'($urandom_range(0, 3)); f++)
          add_frame(i, $urandom_range(1, 12));
      plan();
      run(3000);
    end
    bub_en = 0;
    rand_afull = 0;
    ovf_pct = 0;
    tx_afull = 1'b0;
    tx_overflow = 1'b0;
    cycle();

    // reset in the middle of a frame
    add_frame(3, 6);
    add_frame(1, 4);
    plan();
    repeat (4) cycle();
    rst = 1'b0;
    cycle();
    expq.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    bubble = '0;
    drive();
    m_rr = N - 1;
    exp_trunc = 0;
    exp_ovf = 0;
    cycle();
    chk_reset_outputs();
    rst = 1'b1;
    for (int i = N - 1; i >= 0; i--) add_frame(i, 3);
    plan();
    repeat (3) cycle();
    chk("post_reset_grant", grant_id, 0);
    run(200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
